sd_req_arbiter: RTL and testbench
=================================

Name: sd_req_arbiter

Overview:
- Shares the single SD block-level interface of the IO controller (sd_lba, sd_rd, sd_wr, sd_ack, sector buffer port) between two requesters, e.g. two virtual drives.
- Queues one request per requester, grants round-robin and sequences the rd/wr → ack → transfer → release handshake.
- Gates sector-buffer writes to the granted requester only and multiplexes the granted requester's buffer read data back.
- Sits between the core's drive controllers and the IO controller, in clk_sys.

Parameters:
- TO_BITS, 24, width of ack-wait timeout counter; timeout fires after 2^TO_BITS-1 cycles in WAIT_ACK.

Ports:
- clk_sys  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_rd  in  2  per-requester read request, 1-cycle pulse
- req_wr  in  2  per-requester write request, 1-cycle pulse
- req_lba0  in  32  requester 0 sector address, sampled on its pulse
- req_lba1  in  32  requester 1 sector address, sampled on its pulse
- req_busy  out  2  per-requester: pending or in service
- req_done  out  2  per-requester 1-cycle completion pulse
- req_err  out  2  per-requester 1-cycle timeout pulse
- req_buff_wr  out  2  per-requester gated sector-buffer write strobe
- req_buff_din0  in  8  requester 0 buffer read data
- req_buff_din1  in  8  requester 1 buffer read data
- sd_lba  out  32  to IO controller
- sd_rd  out  1  to IO controller
- sd_wr  out  1  to IO controller
- sd_ack  in  1  from IO controller, SPI-clock domain, asynchronous
- sd_buff_wr  in  1  from IO controller buffer write strobe (clk_sys domain)
- sd_buff_din  out  8  to IO controller, granted requester's read data

Behaviour:
- Reset values: all outputs 0, state IDLE, pending flags 0, last_grant=1 (requester 0 wins first tie), timeout counter 0. Reset mid-transfer drops sd_rd/sd_wr immediately; no done/err is issued.
- sd_ack passes a 2-FF synchroniser (ack_s); only ack_s is used.
- Capture:
  - Pulse on req_rd[n] or req_wr[n] sets pend[n], dir[n] (1=write) and lba[n] on that edge.
  - rd and wr in the same cycle: read taken, write ignored.
  - A pulse while pend[n] is already set is ignored; the first LBA is kept.
  - A pulse while n is in service sets pend[n] (queues the next request).
- req_busy[n] = pend[n] | (n granted and state != IDLE).
- IDLE:
  - If any pend, grant the single pending requester; if both are pending, grant !last_grant.
  - On that edge: clear pend[g], load sd_lba←lba[g], sd_rd←!dir[g], sd_wr←dir[g], clear the counter, go WAIT_ACK.
- WAIT_ACK:
  - ack_s=1: drop sd_rd/sd_wr, go XFER.
  - Else the counter increments. At all-ones: drop sd_rd/sd_wr, pulse req_err[g], last_grant←g, go IDLE.
- XFER:
  - req_buff_wr[g] = sd_buff_wr (combinational); the other requester's bit stays 0.
  - ack_s=0: pulse req_done[g], last_grant←g, go DONE.
- DONE: one idle cycle, then IDLE. This guarantees a gap between consecutive sd_rd/sd_wr assertions.
- sd_buff_din = req_buff_din[g] while state is WAIT_ACK or XFER, else 0 (combinational mux).
- Buffer address and data buses are wired to requesters directly, not through this block.
- req_buff_wr is 0 outside XFER, even if sd_buff_wr toggles.
- Latency:
  - Pulse at edge E sets pend. sd_rd/sd_wr go high at E+1 when IDLE.
  - sd_ack rising is seen via ack_s 2 edges later; sd_rd/sd_wr fall on the following edge.
  - req_done fires on the edge after ack_s falls.
- sd_lba holds its value until the next grant.

Test Plan:
- Single read: req_rd[0] pulse with lba0=0x00000123 → sd_lba=0x123 and sd_rd=1 one edge later. Drive sd_ack high → sd_rd falls 3 edges after the ack rise. 512 sd_buff_wr pulses → 512 req_buff_wr[0] pulses, req_buff_wr[1] stays 0. Drop sd_ack → one req_done[0] pulse, req_busy=00.
- Write data path: req_wr[1] pulse with lba1=0x10 → sd_wr=1, sd_rd=0. Drive req_buff_din1=0xA5 → sd_buff_din=0xA5 throughout XFER, 0 after DONE.
- Contention/round-robin: req_rd pulsed on both requesters in the same cycle after reset → requester 0 served first, then 1 with no extra pulse. Repeat both → requester 1 is not skipped (order follows last_grant).
- Queueing: while requester 0 is in XFER, pulse req_rd[0] with lba0=5, then again with lba0=6 → the second service uses sd_lba=5, and there is at least 1 cycle of sd_rd=0 between grants.
- Timeout: TO_BITS=4, req_rd[0] pulse, sd_ack held 0 → sd_rd drops and req_err[0] pulses after 15 cycles in WAIT_ACK. No req_done; a pending requester 1 is then granted.
- Async reset mid-XFER: assert reset → sd_rd, sd_wr, req_busy, req_buff_wr all 0 immediately. After release, no done/err pulse occurs and a new request is served normally.

Source files
------------

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter that shares one SD block interface between two requesters.
// Grant appears one edge after the request is captured; ack is synchronised by 2 FFs; one pending request is queued per requester.
module sd_req_arbiter #(
  parameter int TO_BITS = 24
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_lba0,
  input  logic [31:0] req_lba1,
  output logic [1:0]  req_busy,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic [1:0]  req_buff_wr,
  input  logic [7:0]  req_buff_din0,
  input  logic [7:0]  req_buff_din1,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, XFER, DONE} state_t;

  localparam logic [TO_BITS-1:0] TO_ONE = TO_BITS'(1);

  state_t             state, state_nxt;
  logic               ack_m, ack_s;
  logic [1:0]         pend, dir;
  logic [31:0]        lba0_q, lba1_q;
  logic               gnt, last_grant;
  logic [TO_BITS-1:0] to_cnt, to_cnt_inc;
  logic               grant_go, gnt_sel, ack_seen, timeout, xfer_end;
  logic [1:0]         gnt_hot;

  assign to_cnt_inc = to_cnt + TO_ONE;
  assign gnt_hot    = gnt ? 2'b10 : 2'b01;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_go  = 1'b0;
    gnt_sel   = gnt;
    ack_seen  = 1'b0;
    timeout   = 1'b0;
    xfer_end  = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          grant_go  = 1'b1;
          gnt_sel   = (&pend) ? ~last_grant : pend[1];
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s) begin
          ack_seen  = 1'b1;
          state_nxt = XFER;
        end else if (&to_cnt_inc) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      XFER: begin
        if (!ack_s) begin
          xfer_end  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ack_m      <= 1'b0;
      ack_s      <= 1'b0;
      pend       <= 2'b00;
      dir        <= 2'b00;
      lba0_q     <= 32'h0;
      lba1_q     <= 32'h0;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      to_cnt     <= '0;
      sd_lba     <= 32'h0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      req_done   <= 2'b00;
      req_err    <= 2'b00;
    end else begin
      ack_m    <= sd_ack;
      ack_s    <= ack_m;
      req_done <= 2'b00;
      req_err  <= 2'b00;

      if (grant_go) begin
        pend[gnt_sel] <= 1'b0;
        gnt           <= gnt_sel;
        sd_lba        <= gnt_sel ? lba1_q : lba0_q;
        sd_rd         <= ~dir[gnt_sel];
        sd_wr         <= dir[gnt_sel];
        to_cnt        <= '0;
      end

      // A requester being granted still has pend set, so capture never collides with the clear.
      if ((req_rd[0] | req_wr[0]) && !pend[0]) begin
        pend[0] <= 1'b1;
        dir[0]  <= ~req_rd[0];
        lba0_q  <= req_lba0;
      end
      if ((req_rd[1] | req_wr[1]) && !pend[1]) begin
        pend[1] <= 1'b1;
        dir[1]  <= ~req_rd[1];
        lba1_q  <= req_lba1;
      end

      if (state == WAIT_ACK && !ack_s)
        to_cnt <= to_cnt_inc;
      if (ack_seen || timeout) begin
        sd_rd <= 1'b0;
        sd_wr <= 1'b0;
      end
      if (timeout) begin
        req_err[gnt] <= 1'b1;
        last_grant   <= gnt;
      end
      if (xfer_end) begin
        req_done[gnt] <= 1'b1;
        last_grant    <= gnt;
      end
    end
  end

  assign req_busy    = pend | ((state != IDLE) ? gnt_hot : 2'b00);
  assign req_buff_wr = (state == XFER && sd_buff_wr) ? gnt_hot : 2'b00;
  assign sd_buff_din = (state == WAIT_ACK || state == XFER) ?
                       (gnt ? req_buff_din1 : req_buff_din0) : 8'h00;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: directed scenarios plus random traffic, all cycles compared
// against a behavioural model of the arbitration rules.
module tb_sd_req_arbiter;

  localparam int TO = 4;
  localparam int TO_CYC = (1 << TO) - 1;
  localparam int P_IDLE = 0, P_WAIT = 1, P_XFER = 2, P_DONE = 3;

  logic        clk_sys;
  logic        reset;
  logic [1:0]  req_rd, req_wr;
  logic [31:0] req_lba0, req_lba1;
  logic [1:0]  req_busy, req_done, req_err, req_buff_wr;
  logic [7:0]  req_buff_din0, req_buff_din1;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack, sd_buff_wr;
  logic [7:0]  sd_buff_din;

  int checks = 0;
  int errors = 0;

  sd_req_arbiter #(.TO_BITS(TO)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .req_rd(req_rd), .req_wr(req_wr),
    .req_lba0(req_lba0), .req_lba1(req_lba1),
    .req_busy(req_busy), .req_done(req_done), .req_err(req_err),
    .req_buff_wr(req_buff_wr),
    .req_buff_din0(req_buff_din0), .req_buff_din1(req_buff_din1),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the interface, what each requester has queued,
  // and the synchronised view of sd_ack.
  logic [1:0]  m_pend, m_dir, m_done, m_err;
  logic [31:0] m_lba [2];
  logic [31:0] m_sdlba;
  logic        m_g, m_last, m_rd, m_wr, a1, a2;
  int          m_ph, m_waited;

  task automatic model_reset();
    m_pend = 0; m_dir = 0; m_done = 0; m_err = 0;
    m_lba[0] = 0; m_lba[1] = 0; m_sdlba = 0;
    m_g = 0; m_last = 1; m_rd = 0; m_wr = 0; a1 = 0; a2 = 0;
    m_ph = P_IDLE; m_waited = 0;
  endtask

  task automatic model_step();
    logic       acks;
    logic [1:0] p_old;
    acks = a2; a2 = a1; a1 = sd_ack;
    p_old = m_pend; m_done = 0; m_err = 0;
    for (int n = 0; n < 2; n++)
      if ((req_rd[n] || req_wr[n]) && !p_old[n]) begin
        m_pend[n] = 1'b1;
        m_dir[n]  = !req_rd[n];
        m_lba[n]  = (n == 1) ? req_lba1 : req_lba0;
      end
    case (m_ph)
      P_IDLE: if (p_old != 0) begin
        m_g = (p_old == 2'b11) ? !m_last : p_old[1];
        m_pend[m_g] = 1'b0;
        m_sdlba = m_lba[m_g];
        m_rd = !m_dir[m_g]; m_wr = m_dir[m_g];
        m_waited = 0; m_ph = P_WAIT;
      end
      P_WAIT: if (acks) begin
        m_rd = 0; m_wr = 0; m_ph = P_XFER;
      end else begin
        m_waited++;
        if (m_waited == TO_CYC) begin
          m_rd = 0; m_wr = 0; m_err[m_g] = 1'b1; m_last = m_g; m_ph = P_IDLE;
        end
      end
      P_XFER: if (!acks) begin
        m_done[m_g] = 1'b1; m_last = m_g; m_ph = P_DONE;
      end
      default: m_ph = P_IDLE;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_sys or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  task automatic compare_all();
    logic [1:0] ghot, eb, ew;
    logic [7:0] ed;
    ghot = m_g ? 2'b10 : 2'b01;
    eb = m_pend | ((m_ph != P_IDLE) ? ghot : 2'b00);
    ew = (m_ph == P_XFER && sd_buff_wr) ? ghot : 2'b00;
    ed = (m_ph == P_WAIT || m_ph == P_XFER) ? (m_g ? req_buff_din1 : req_buff_din0) : 8'h00;
    chk("m_sd_rd", 32'(sd_rd), 32'(m_rd));
    chk("m_sd_wr", 32'(sd_wr), 32'(m_wr));
    chk("m_sd_lba", sd_lba, m_sdlba);
    chk("m_busy", 32'(req_busy), 32'(eb));
    chk("m_done", 32'(req_done), 32'(m_done));
    chk("m_err", 32'(req_err), 32'(m_err));
    chk("m_buff_wr", 32'(req_buff_wr), 32'(ew));
    chk("m_buff_din", 32'(sd_buff_din), 32'(ed));
  endtask

  initial forever begin
    @(negedge clk_sys);
    if (!reset) compare_all();
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic wait_req(output logic [31:0] l);
    int n = 0;
    while (!(sd_rd || sd_wr) && n < 50) begin
      cyc(1);
      n++;
    end
    chk("grant_seen", 32'(sd_rd | sd_wr), 32'd1);
    l = sd_lba;
  endtask

  task automatic finish_req(input int pulses);
    int n = 0;
    sd_ack = 1'b1;
    while ((sd_rd || sd_wr) && n < 10) begin
      cyc(1);
      n++;
    end
    chk("ack_taken", 32'(sd_rd | sd_wr), 32'd0);
    repeat (pulses) begin
      sd_buff_wr = 1'b1; cyc(1);
      sd_buff_wr = 1'b0; cyc(1);
    end
    sd_ack = 1'b0;
    cyc(3);
  endtask

  initial begin
    logic [31:0] l;
    int c0, c1, nd, ne, n;
    reset = 1'b0;
    req_rd = 0; req_wr = 0; req_lba0 = 0; req_lba1 = 0;
    req_buff_din0 = 0; req_buff_din1 = 0; sd_ack = 0; sd_buff_wr = 0;
    #1 reset = 1'b1;
    cyc(3);
    chk("rst_sd_rd", 32'(sd_rd), 0);
    chk("rst_sd_wr", 32'(sd_wr), 0);
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_busy", 32'(req_busy), 0);
    chk("rst_done_err", 32'({req_done, req_err}), 0);
    chk("rst_din", 32'(sd_buff_din), 0);
    reset = 1'b0;
    cyc(1);

    // Single read with a full 512-byte sector
    req_lba0 = 32'h123; req_rd = 2'b01; cyc(1); req_rd = 0;
    chk("t1_busy_pend", 32'(req_busy), 32'b01);
    chk("t1_rd_not_yet", 32'(sd_rd), 0);
    cyc(1);
    chk("t1_sd_rd", 32'(sd_rd), 1);
    chk("t1_lba", sd_lba, 32'h123);
    sd_ack = 1'b1; cyc(2);
    chk("t1_rd_held", 32'(sd_rd), 1);
    cyc(1);
    chk("t1_rd_fall", 32'(sd_rd), 0);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 512; i++) begin
      sd_buff_wr = 1'b1; #1;
      c0 += int'(req_buff_wr[0]); c1 += int'(req_buff_wr[1]);
      cyc(1); sd_buff_wr = 1'b0; cyc(1);
    end
    chk("t1_bwr0_cnt", c0, 512);
    chk("t1_bwr1_cnt", c1, 0);
    sd_ack = 1'b0; nd = 0;
    repeat (5) begin cyc(1); nd += int'(req_done[0]); end
    chk("t1_done_cnt", nd, 1);
    chk("t1_busy_idle", 32'(req_busy), 0);

    // Write on requester 1, read data mux
    req_lba1 = 32'h10; req_buff_din1 = 8'hA5; req_wr = 2'b10; cyc(1); req_wr = 0;
    cyc(1);
    chk("t2_sd_wr", 32'(sd_wr), 1);
    chk("t2_sd_rd", 32'(sd_rd), 0);
    chk("t2_lba", sd_lba, 32'h10);
    sd_ack = 1'b1; cyc(3);
    chk("t2_din_xfer", 32'(sd_buff_din), 32'hA5);
    sd_ack = 1'b0; cyc(4);
    chk("t2_din_after", 32'(sd_buff_din), 0);

    // Contention straight after reset: requester 0 first, then 1, twice
    reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
    req_lba0 = 32'hA0; req_lba1 = 32'hB1;
    for (int r = 0; r < 2; r++) begin
      req_rd = 2'b11; cyc(1); req_rd = 0;
      for (int k = 0; k < 2; k++) begin
        wait_req(l);
        chk($sformatf("t3_order_r%0d_k%0d", r, k), l, (k == 1) ? 32'hB1 : 32'hA0);
        finish_req(4);
      end
    end

    // Queueing during service keeps the first queued LBA
    req_lba0 = 32'h1; req_rd = 2'b01; cyc(1); req_rd = 0;
    wait_req(l);
    sd_ack = 1'b1; n = 0;
    while (sd_rd && n < 10) begin cyc(1); n++; end
    req_lba0 = 32'h5; req_rd = 2'b01; cyc(1);
    req_lba0 = 32'h6; cyc(1); req_rd = 0;
    finish_req(2);
    chk("t4_gap", 32'(sd_rd), 0);
    wait_req(l);
    chk("t4_queued_lba", l, 32'h5);
    finish_req(1);

    // Timeout on requester 0, then queued requester 1 gets the interface
    req_lba0 = 32'h77; req_rd = 2'b01; cyc(1);
    req_lba1 = 32'h88; req_rd = 2'b10; cyc(1); req_rd = 0;
    n = 0;
    while (sd_rd && n < 40) begin n++; cyc(1); end
    chk("t5_wait_cycles", n, TO_CYC);
    chk("t5_err", 32'(req_err), 32'b01);
    cyc(1);
    chk("t5_next_grant", sd_lba, 32'h88);
    chk("t5_next_rd", 32'(sd_rd), 1);
    finish_req(1);

    // Asynchronous reset in the middle of a transfer
    req_lba0 = 32'h42; req_rd = 2'b01; cyc(1); req_rd = 0;
    wait_req(l);
    sd_ack = 1'b1; cyc(3);
    sd_buff_wr = 1'b1; #1;
    chk("t6_bwr_pre", 32'(req_buff_wr), 32'b01);
    #1 reset = 1'b1; #1;
    chk("t6_rst_rd_wr", 32'({sd_rd, sd_wr}), 0);
    chk("t6_rst_busy", 32'(req_busy), 0);
    chk("t6_rst_bwr", 32'(req_buff_wr), 0);
    sd_buff_wr = 1'b0; sd_ack = 1'b0;
    cyc(2); reset = 1'b0;
    nd = 0; ne = 0;
    repeat (6) begin cyc(1); nd += int'(|req_done); ne += int'(|req_err); end
    chk("t6_no_done", nd, 0);
    chk("t6_no_err", ne, 0);
    req_lba1 = 32'h99; req_rd = 2'b10; cyc(1); req_rd = 0;
    wait_req(l);
    chk("t6_new_lba", l, 32'h99);
    finish_req(3);

    // Random traffic with a loosely reactive IO controller
    for (int i = 0; i < 4000; i++) begin
      req_rd = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      req_wr = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      req_lba0 = $urandom; req_lba1 = $urandom;
      req_buff_din0 = 8'($urandom); req_buff_din1 = 8'($urandom);
      sd_buff_wr = 1'($urandom_range(0, 1));
      if (!sd_ack && (sd_rd || sd_wr) && $urandom_range(0, 5) == 0)
        sd_ack = 1'b1;
      else if (sd_ack && !(sd_rd || sd_wr) && $urandom_range(0, 7) == 0)
        sd_ack = 1'b0;
      cyc(1);
    end
    req_rd = 0; req_wr = 0; sd_buff_wr = 0; sd_ack = 0;
    cyc(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
